// File: rtl/int_alu.sv
// int_alu: 32-bit integer ALU for the execute stage.
// Combinational operation select feeding a single result register; the zero
// flag is decoded from that register so it always matches the visible result.
// No handshake: one operation accepted and one result produced every cycle.
module int_alu (
  input  logic        clk,
  input  logic        rst_n,
  output logic        zero,
  output logic [31:0] result,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [2:0]  select,
  input  logic        rotate
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [31:0] result_d;
  logic [31:0] result_q;

  // Only the low five bits of data2 matter for any shift or rotate.
  logic [4:0]  shamt;
  logic [63:0] dbl;
  logic [63:0] dbl_left;
  logic [63:0] dbl_right;
  logic [31:0] shl_res;
  logic [31:0] shr_res;
  logic        slt_bit;

  assign shamt = data2[4:0];

  // Rotates are taken from a doubled copy of the operand: shifting the
  // 64-bit pair brings the wrapped bits into the 32-bit window, and an amount
  // of zero naturally returns data1 unchanged.
  assign dbl       = {data1, data1};
  assign dbl_left  = dbl << shamt;
  assign dbl_right = dbl >> shamt;

  // Left shift family: plain logical shift or rotate, chosen by rotate.
  always_comb begin
    shl_res = data1 << shamt;
    if (rotate) begin
      shl_res = dbl_left[63:32];
    end
  end

  // Right shift family: plain logical shift or rotate, chosen by rotate.
  always_comb begin
    shr_res = data1 >> shamt;
    if (rotate) begin
      shr_res = dbl_right[31:0];
    end
  end

  assign slt_bit = ($signed(data1) < $signed(data2));

  // Operation select; every encoding is defined, so no fallback is needed
  // beyond the default assignment.
  always_comb begin
    result_d = 32'd0;
    unique case (select)
      OP_ADD: result_d = data1 + data2;
      OP_SUB: result_d = data1 - data2;
      OP_AND: result_d = data1 & data2;
      OP_OR:  result_d = data1 | data2;
      OP_XOR: result_d = data1 ^ data2;
      OP_SLT: result_d = {31'd0, slt_bit};
      OP_SHL: result_d = shl_res;
      OP_SHR: result_d = shr_res;
      default: result_d = 32'd0;
    endcase
  end

  // Result register; reset clears it immediately and drops any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 32'd0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign zero   = (result_q == 32'd0);

endmodule

// File: tb/tb_int_alu.sv
// tb_int_alu: directed and random checks of int_alu against an arithmetic
// reference model.
module tb_int_alu;

  logic        clk;
  logic        rst_n;
  logic        zero;
  logic [31:0] result;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [2:0]  select;
  logic        rotate;

  int checks;
  int errors;

  int_alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .zero   (zero),
    .result (result),
    .data1  (data1),
    .data2  (data2),
    .select (select),
    .rotate (rotate)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built from integer arithmetic on 64-bit values:
  // shifts are multiply/divide by powers of two, rotates are the sum of the
  // two shifted pieces, and right rotate is left rotate by the complement.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] sel, input logic rot);
    longint unsigned ua, ub, m, p, amt, lamt;
    ua  = a;
    ub  = b;
    m   = 64'd1 << 32;
    amt = ub % 32;
    case (sel)
      3'd0: return 32'((ua + ub) % m);
      3'd1: return 32'((ua + m - ub) % m);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: begin
        p = 64'd1 << amt;
        if (!rot) return 32'((ua * p) % m);
        return 32'(((ua * p) % m) + ua / (m / p));
      end
      default: begin
        if (!rot) return 32'(ua / (64'd1 << amt));
        lamt = (32 - amt) % 32;
        p = 64'd1 << lamt;
        return 32'(((ua * p) % m) + ua / (m / p));
      end
    endcase
  endfunction

  // Compare one observed value against its expectation.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check both outputs; zero must agree with the expected result.
  task automatic check_out(input string tag, input logic [31:0] exp);
    check({tag, ".result"}, result, exp);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
  endtask

  // Drive one operation at the falling edge, check it just after the next
  // rising edge against an explicitly given value.
  task automatic op_exp(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] sel, input logic rot, input logic [31:0] exp);
    @(negedge clk);
    data1  = a;
    data2  = b;
    select = sel;
    rotate = rot;
    @(posedge clk);
    #1;
    check_out(tag, exp);
  endtask

  // Same, with the expectation taken from the reference model.
  task automatic op_model(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] sel, input logic rot);
    op_exp(tag, a, b, sel, rot, model(a, b, sel, rot));
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] ra, rb;
  logic [2:0]  rs;
  logic        rr;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    data1  = $urandom;
    data2  = $urandom;
    select = 3'($urandom_range(0, 7));
    rotate = 1'($urandom_range(0, 1));

    // Reset: outputs cleared at once and held across edges.
    #1;
    check_out("reset_immediate", 32'd0);
    repeat (3) begin
      @(negedge clk);
      data1  = $urandom;
      data2  = $urandom;
      select = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      check_out("reset_hold", 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    op_exp("post_reset_add", 32'd3, 32'd1, 3'b000, 1'b0, 32'd4);

    // Basic ops, rotate=1.
    op_exp("add", 32'd3, 32'd1, 3'b000, 1'b1, 32'd4);
    op_exp("sub", 32'd3, 32'd1, 3'b001, 1'b1, 32'd2);
    op_exp("and", 32'd3, 32'd1, 3'b010, 1'b1, 32'd1);
    op_exp("or",  32'd3, 32'd1, 3'b011, 1'b1, 32'd3);
    op_exp("xor", 32'd3, 32'd1, 3'b100, 1'b1, 32'd2);
    op_exp("slt", 32'd3, 32'd1, 3'b101, 1'b1, 32'd0);
    op_exp("rol", 32'd3, 32'd1, 3'b110, 1'b1, 32'd6);
    op_exp("ror", 32'd3, 32'd1, 3'b111, 1'b1, 32'h8000_0001);
    op_exp("sll", 32'd3, 32'd1, 3'b110, 1'b0, 32'd6);
    op_exp("srl", 32'd3, 32'd1, 3'b111, 1'b0, 32'd1);

    // Signed compare and wrap-around.
    op_exp("slt_neg",  32'hFFFF_FFFF, 32'd1, 3'b101, 1'b0, 32'd1);
    op_exp("add_wrap", 32'hFFFF_FFFF, 32'd1, 3'b000, 1'b0, 32'd0);
    op_exp("sub_wrap", 32'd0,         32'd1, 3'b001, 1'b0, 32'hFFFF_FFFF);

    // Shift boundaries.
    op_exp("sll0",  32'h8000_0001, 32'd0,  3'b110, 1'b0, 32'h8000_0001);
    op_exp("rol0",  32'h8000_0001, 32'd0,  3'b110, 1'b1, 32'h8000_0001);
    op_exp("srl0",  32'h8000_0001, 32'd0,  3'b111, 1'b0, 32'h8000_0001);
    op_exp("ror0",  32'h8000_0001, 32'd0,  3'b111, 1'b1, 32'h8000_0001);
    op_exp("sll31", 32'h8000_0001, 32'd31, 3'b110, 1'b0, 32'h8000_0000);
    op_exp("rol31", 32'h8000_0001, 32'd31, 3'b110, 1'b1, 32'hC000_0000);
    op_exp("srl31", 32'h8000_0001, 32'd31, 3'b111, 1'b0, 32'd1);
    op_exp("ror_hi_ignored", 32'h8000_0001, 32'h0000_0021, 3'b111, 1'b1, 32'hC000_0000);
    op_exp("sll_hi_ignored", 32'h0000_0003, 32'hFFFF_FFE2, 3'b110, 1'b0, 32'h0000_000C);

    // Rotate independence for the non-shift ops.
    for (int s = 0; s < 6; s++) begin
      ra = $urandom;
      rb = $urandom;
      op_model($sformatf("rotind_sel%0d_r0", s), ra, rb, 3'(s), 1'b0);
      op_model($sformatf("rotind_sel%0d_r1", s), ra, rb, 3'(s), 1'b1);
    end

    // Back-to-back random stream: inputs change every cycle, expected values
    // queued when driven and popped one edge later.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rs = 3'($urandom_range(0, 7));
      rr = 1'($urandom_range(0, 1));
      data1  = ra;
      data2  = rb;
      select = rs;
      rotate = rr;
      exp_q.push_back(model(ra, rb, rs, rr));
      @(posedge clk);
      #1;
      check_out($sformatf("stream%0d", i), exp_q.pop_front());
    end

    // Mid-cycle reset pulse: clears at once, then fresh inputs load.
    @(negedge clk);
    data1  = 32'd10;
    data2  = 32'd5;
    select = 3'b000;
    rotate = 1'b0;
    @(posedge clk);
    #1;
    check_out("pre_pulse", 32'd15);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("pulse_immediate", 32'd0);
    @(negedge clk);
    data1  = 32'h0000_00F0;
    data2  = 32'h0000_000F;
    select = 3'b011;
    #1;
    check_out("pulse_hold", 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("post_pulse", 32'h0000_00FF);

    // Reset asserted with an op in flight: no partial result appears.
    @(negedge clk);
    data1  = 32'd7;
    data2  = 32'd9;
    select = 3'b000;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_out("inflight_discard", 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    data1  = 32'd7;
    data2  = 32'd9;
    select = 3'b001;
    @(posedge clk);
    #1;
    check_out("after_discard", 32'hFFFF_FFFE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
